rx_iq_word_packer: RTL and testbench

Receiver output stage directly downstream of the per-channel DC offset correction. It accepts one corrected 24-bit I/Q sample pair per input strobe and buffers pairs in a small FIFO. Each pair is serialised as three 16-bit words over a valid/ready handshake toward the host-bus transmit logic. The block absorbs bus backpressure and flags dropped samples.

---
 rtl/rx_iq_word_packer_pkg.sv | 13 +
 rtl/rx_iq_word_packer_if.sv | 12 +
 rtl/rx_iq_word_packer_fifo.sv | 39 +++
 rtl/rx_iq_word_packer.sv | 65 ++++++
 tb/tb_rx_iq_word_packer.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/rx_iq_word_packer_pkg.sv
// rx_pkg: shared widths, FSM states and word-slice helper for the I/Q word packer
package rx_pkg;
    localparam int SAMPLE_W = 24;
    localparam int WORD_W = 16;
    localparam int PAIR_W = 2 * SAMPLE_W;
    localparam int W0_LSB = 32;
    localparam int W1_LSB = 16;
    localparam int W2_LSB = 0;
    typedef enum logic [1:0] {IDLE, W0, W1, W2} state_t;
    function automatic logic [WORD_W-1:0] pair_word(input logic [PAIR_W-1:0] p, input logic [1:0] idx);
        pair_word = idx == 2'd0 ? p[W0_LSB +: WORD_W] : idx == 2'd1 ? p[W1_LSB +: WORD_W] : p[W2_LSB +: WORD_W];
    endfunction
endpackage

// File: rtl/rx_iq_word_packer_if.sv
// rx_iq_word_packer_if: sample strobe input and 16-bit valid/ready word stream
interface rx_iq_word_packer_if;
    import rx_pkg::*;
    logic                in_valid;
    logic [SAMPLE_W-1:0] i_data;
    logic [SAMPLE_W-1:0] q_data;
    logic [WORD_W-1:0]   out_data;
    logic                out_valid;
    logic                out_ready;
    modport master (output in_valid, i_data, q_data, out_ready, input out_data, out_valid);
    modport slave (input in_valid, i_data, q_data, out_ready, output out_data, out_valid);
endinterface

// File: rtl/rx_iq_word_packer_fifo.sv
// rx_pair_fifo: single-clock FIFO of 48-bit I/Q pairs with count and full/empty flags
module rx_pair_fifo
    import rx_pkg::*;
#(
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [PAIR_W-1:0] push_data,
    input  logic              pop,
    output logic [PAIR_W-1:0] pop_data,
    output logic [AW:0]       count,
    output logic              full,
    output logic              empty
);
    logic [PAIR_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    assign pop_data = mem[rd_ptr];
    assign full = count == (AW+1)'(DEPTH);
    assign empty = count == '0;
    // push at full is only issued alongside a pop, so the slot being read is the one overwritten
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(push);
            rd_ptr <= rd_ptr + AW'(pop);
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end
endmodule

// File: rtl/rx_iq_word_packer.sv
// rx_iq_word_packer: buffers corrected I/Q pairs and serialises each as three 16-bit words
module rx_iq_word_packer
    import rx_pkg::*;
#(
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                rst,
    rx_iq_word_packer_if.slave  bus,
    output logic [AW:0]         fill,
    output logic                overflow,
    input  logic                clr_ovf
);
    state_t            state, state_n;
    logic [PAIR_W-1:0] hold, hold_n, pop_data;
    logic [WORD_W-1:0] data_n;
    logic              valid_n, pop, accept, xfer, full, empty;
    assign xfer = bus.out_valid && bus.out_ready;
    assign pop = !empty && (state == IDLE || (state == W2 && xfer));
    assign accept = bus.in_valid && (!full || pop);
    rx_pair_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk(clk),
        .rst(rst),
        .push(accept),
        .push_data({bus.i_data, bus.q_data}),
        .pop(pop),
        .pop_data(pop_data),
        .count(fill),
        .full(full),
        .empty(empty)
    );
    // a pop always starts a fresh pair at W0, which gives the no-bubble reload out of W2
    always_comb begin
        state_n = state;
        hold_n = hold;
        data_n = bus.out_data;
        valid_n = bus.out_valid;
        if (pop) begin
            state_n = W0;
            hold_n = pop_data;
            data_n = pair_word(pop_data, 2'd0);
            valid_n = 1'b1;
        end else if (xfer) begin
            state_n = state == W0 ? W1 : state == W1 ? W2 : IDLE;
            data_n = pair_word(hold, state == W0 ? 2'd1 : 2'd2);
            valid_n = state != W2;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            hold <= '0;
            bus.out_data <= '0;
            bus.out_valid <= 1'b0;
            overflow <= 1'b0;
        end else begin
            state <= state_n;
            hold <= hold_n;
            bus.out_data <= data_n;
            bus.out_valid <= valid_n;
            overflow <= (bus.in_valid && !accept) ? 1'b1 : clr_ovf ? 1'b0 : overflow;
        end
    end
endmodule

// File: tb/tb_rx_iq_word_packer.sv
// tb_rx_iq_word_packer: directed stimulus checked against a queue-based pair/word model
module tb_rx_iq_word_packer;
    import rx_pkg::*;
    localparam int DEPTH = 8;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clr_ovf = 1'b0;
    logic [3:0] fill;
    logic       overflow;
    rx_iq_word_packer_if bus ();
    rx_iq_word_packer #(.DEPTH(DEPTH)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .fill(fill),
        .overflow(overflow),
        .clr_ovf(clr_ovf)
    );
    always #5 clk = ~clk;
    int vectors = 0;
    int errors = 0;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    function automatic logic [15:0] spec_word(input logic [47:0] p, input int idx);
        logic [23:0] i;
        logic [23:0] q;
        i = p[47:24];
        q = p[23:0];
        case (idx)
            0: return i[23:8];
            1: return {i[7:0], q[23:16]};
            default: return q[15:0];
        endcase
    endfunction
    function automatic logic [23:0] pi(input int k);
        return 24'(24'h100000 + k * 24'h010101);
    endfunction
    function automatic logic [23:0] pq(input int k);
        return 24'(24'h800000 | k);
    endfunction
    // model: pairs waiting, plus words still owed from the pair being sent
    logic [47:0] m_q[$];
    logic [47:0] m_cur = '0;
    int          m_rem = 0;
    logic        m_ovf = 1'b0;
    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            m_q.delete();
            m_rem = 0;
            m_ovf = 1'b0;
        end else begin
            bit xf, pp, acc;
            xf = m_rem > 0 && bus.out_ready;
            pp = m_q.size() > 0 && (m_rem == 0 || (m_rem == 1 && xf));
            acc = bus.in_valid && (m_q.size() < DEPTH || pp);
            if (xf) m_rem--;
            if (pp) begin
                m_cur = m_q.pop_front();
                m_rem = 3;
            end
            if (acc) m_q.push_back({bus.i_data, bus.q_data});
            if (bus.in_valid && !acc) m_ovf = 1'b1;
            else if (clr_ovf) m_ovf = 1'b0;
        end
    end
    always @(negedge clk) begin
        if (!rst) begin
            chk("model_out_valid", 32'(bus.out_valid), 32'(m_rem > 0));
            chk("model_fill", 32'(fill), 32'(m_q.size()));
            chk("model_overflow", 32'(overflow), 32'(m_ovf));
            if (m_rem > 0) chk("model_out_data", 32'(bus.out_data), 32'(spec_word(m_cur, 3 - m_rem)));
        end
    end
    task automatic strobe(input logic [23:0] i, input logic [23:0] q);
        bus.in_valid = 1'b1;
        bus.i_data = i;
        bus.q_data = q;
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask
    initial begin
        int words, gaps;
        logic [15:0] last;
        bus.in_valid = 1'b0;
        bus.i_data = '0;
        bus.q_data = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_valid", 32'(bus.out_valid), 0);
        chk("rst_data", 32'(bus.out_data), 0);
        chk("rst_fill", 32'(fill), 0);
        chk("rst_ovf", 32'(overflow), 0);
        rst = 1'b0;
        bus.out_ready = 1'b1;
        strobe(24'h123456, 24'hABCDEF);
        chk("t1_fill", 32'(fill), 1);
        chk("t1_latency", 32'(bus.out_valid), 0);
        @(negedge clk);
        chk("t1_valid", 32'(bus.out_valid), 1);
        chk("t1_w0", 32'(bus.out_data), 32'h1234);
        @(negedge clk);
        chk("t1_w1", 32'(bus.out_data), 32'h56AB);
        @(negedge clk);
        chk("t1_w2", 32'(bus.out_data), 32'hCDEF);
        @(negedge clk);
        chk("t1_idle", 32'(bus.out_valid), 0);
        chk("t1_fill0", 32'(fill), 0);
        strobe(24'h123456, 24'hABCDEF);
        repeat (2) @(negedge clk);
        chk("t2_w1", 32'(bus.out_data), 32'h56AB);
        bus.out_ready = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("t2_hold_data", 32'(bus.out_data), 32'h56AB);
            chk("t2_hold_valid", 32'(bus.out_valid), 1);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("t2_w2", 32'(bus.out_data), 32'hCDEF);
        @(negedge clk);
        chk("t2_idle", 32'(bus.out_valid), 0);
        bus.out_ready = 1'b0;
        for (int k = 0; k < 10; k++) strobe(pi(k), pq(k));
        chk("t3_fill", 32'(fill), 8);
        chk("t3_ovf", 32'(overflow), 1);
        clr_ovf = 1'b1;
        @(negedge clk);
        clr_ovf = 1'b0;
        chk("t3_clr", 32'(overflow), 0);
        bus.out_ready = 1'b1;
        words = 0;
        last = '0;
        for (int n = 0; n < 40; n++) begin
            if (bus.out_valid) begin
                words++;
                last = bus.out_data;
            end
            @(negedge clk);
        end
        chk("t3_words", 32'(words), 27);
        chk("t3_last", 32'(last), 32'h0008);
        bus.out_ready = 1'b0;
        for (int k = 10; k < 13; k++) strobe(pi(k), pq(k));
        @(negedge clk);
        bus.out_ready = 1'b1;
        gaps = 0;
        for (int n = 0; n < 9; n++) begin
            if (!bus.out_valid) gaps++;
            @(negedge clk);
        end
        chk("t4_gaps", 32'(gaps), 0);
        chk("t4_end", 32'(bus.out_valid), 0);
        bus.out_ready = 1'b0;
        for (int k = 20; k < 29; k++) strobe(pi(k), pq(k));
        chk("t5_full", 32'(fill), 8);
        bus.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        strobe(pi(30), pq(30));
        chk("t5_fill", 32'(fill), 8);
        chk("t5_ovf", 32'(overflow), 0);
        chk("t5_next_w0", 32'(bus.out_data), 32'h2515);
        repeat (40) @(negedge clk);
        chk("t5_drained", 32'(fill), 0);
        bus.out_ready = 1'b0;
        for (int k = 40; k < 45; k++) strobe(pi(k), pq(k));
        chk("t6_fill", 32'(fill), 4);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk("t6_w1", 32'(bus.out_data), 32'h2880);
        #2 rst = 1'b1;
        #1;
        chk("t6_rst_valid", 32'(bus.out_valid), 0);
        chk("t6_rst_data", 32'(bus.out_data), 0);
        chk("t6_rst_fill", 32'(fill), 0);
        @(negedge clk);
        rst = 1'b0;
        bus.out_ready = 1'b1;
        strobe(24'h123456, 24'hABCDEF);
        chk("t6_lat", 32'(bus.out_valid), 0);
        @(negedge clk);
        chk("t6_valid", 32'(bus.out_valid), 1);
        chk("t6_w0", 32'(bus.out_data), 32'h1234);
        repeat (4) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
